mem_req_ctrl: RTL

Multicycle memory-access controller. It sits directly upstream of the load/store byte-lane formatter in the CPU's MEM stage. On a single-cycle start it latches the effective address, the pre-formatted store data and the byte strobes, then runs the valid/ready handshake with the external memory port. For loads, it captures the raw 32-bit read word and the byte offset so the formatter can extract the byte or halfword. It reports completion with a one-cycle `done` pulse and keeps a busy-cycle counter for performance statistics.

---
 rtl/mem_req_ctrl_pkg.sv | 15 +
 rtl/mem_req_ctrl.sv | 100 ++++++++++
 2 files changed

// File: rtl/mem_req_ctrl_pkg.sv
// Shared definitions for the MEM-stage memory request controller:
// state encoding and the word-align mask applied to the request address.
package mem_req_defs;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_REQ  = 3'd1,
    S_RD_WAIT = 3'd2,
    S_WR_REQ  = 3'd3,
    S_FIN     = 3'd4
  } state_e;

  localparam logic [31:0] WORD_ALIGN_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/mem_req_ctrl.sv
// Multicycle memory-access controller: latches a load/store request, runs the
// valid/ready handshake with memory, captures the load word, counts busy cycles.
module mem_req_ctrl
  import mem_req_defs::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        is_load,
  input  logic        is_store,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  output logic [31:0] Address,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Write_data,
  output logic [3:0]  Write_strb,
  input  logic        Mem_Req_Ready,
  input  logic [31:0] Read_data,
  input  logic        Read_data_Valid,
  output logic        Read_data_Ready,
  output logic [31:0] load_word,
  output logic [1:0]  ea,
  output logic        busy,
  output logic        done,
  output logic [31:0] busy_cycles
);

  state_e      state_q, state_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  wstrb_q, wstrb_d;
  logic [31:0] load_word_q, load_word_d;
  logic [31:0] busy_cycles_q, busy_cycles_d;

  always_comb begin
    state_d       = state_q;
    addr_d        = addr_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    load_word_d   = load_word_q;
    busy_cycles_d = (state_q != S_IDLE) ? busy_cycles_q + 32'd1 : busy_cycles_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          addr_d  = addr;
          wdata_d = wdata;
          wstrb_d = wstrb;
          // store has priority when both flags are set
          if (is_store)     state_d = S_WR_REQ;
          else if (is_load) state_d = S_RD_REQ;
          else              state_d = S_FIN;
        end
      end
      S_RD_REQ:  if (Mem_Req_Ready) state_d = S_RD_WAIT;
      S_RD_WAIT: begin
        if (Read_data_Valid) begin
          load_word_d = Read_data;
          state_d     = S_FIN;
        end
      end
      S_WR_REQ:  if (Mem_Req_Ready) state_d = S_FIN;
      S_FIN:     state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      addr_q        <= '0;
      wdata_q       <= '0;
      wstrb_q       <= '0;
      load_word_q   <= '0;
      busy_cycles_q <= '0;
    end else begin
      state_q       <= state_d;
      addr_q        <= addr_d;
      wdata_q       <= wdata_d;
      wstrb_q       <= wstrb_d;
      load_word_q   <= load_word_d;
      busy_cycles_q <= busy_cycles_d;
    end
  end

  // Moore outputs straight off the state register, so reset clears them at once
  assign MemRead         = (state_q == S_RD_REQ);
  assign MemWrite        = (state_q == S_WR_REQ);
  assign Read_data_Ready = (state_q == S_RD_WAIT);
  assign done            = (state_q == S_FIN);
  assign busy            = (state_q != S_IDLE);
  assign Address         = addr_q & WORD_ALIGN_MASK;
  assign Write_data      = wdata_q;
  assign Write_strb      = wstrb_q;
  assign ea              = addr_q[1:0];
  assign load_word       = load_word_q;
  assign busy_cycles     = busy_cycles_q;

endmodule
